// File: rtl/cpu_cycle_sequencer_if.sv
// rtl/cpu_cycle_sequencer_if.sv - microcode <-> cycle sequencer signal bundle
// master: microcode/control side, slave: cpu_cycle_sequencer
interface cpu_cycle_sequencer_if #(
  parameter int T_STATES = 4,
  parameter int M_CYCLES = 8
);
  logic                i_IR_Fetch;
  logic                i_Cond_Eval;
  logic                i_Cond_True;
  logic                i_Halt_Req;
  logic                i_Wake;
  logic                i_Stall;
  logic [T_STATES-1:0] o_Cycle_Step;
  logic [M_CYCLES-1:0] o_Cycle_Count;
  logic [1:0]          o_P;
  logic                o_Active;
  logic                o_Instr_Done;
  logic                o_Halted;
  logic                o_Fault;

  modport master (
    output i_IR_Fetch, i_Cond_Eval, i_Cond_True, i_Halt_Req, i_Wake, i_Stall,
    input  o_Cycle_Step, o_Cycle_Count, o_P, o_Active, o_Instr_Done, o_Halted, o_Fault
  );

  modport slave (
    input  i_IR_Fetch, i_Cond_Eval, i_Cond_True, i_Halt_Req, i_Wake, i_Stall,
    output o_Cycle_Step, o_Cycle_Count, o_P, o_Active, o_Instr_Done, o_Halted, o_Fault
  );
endinterface

// File: rtl/cpu_cycle_sequencer.sv
// rtl/cpu_cycle_sequencer.sv - T-state / M-cycle timing generator for the control unit
// Optional bus-stall freeze enabled by defining CYCLE_SEQ_STALL_EN.
module cpu_cycle_sequencer #(
  parameter int T_STATES = 4,
  parameter int M_CYCLES = 8
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  cpu_cycle_sequencer_if.slave  bus
);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  localparam logic [T_STATES-1:0] STEP_FIRST  = T_STATES'(1);
  localparam logic [M_CYCLES-1:0] COUNT_FIRST = M_CYCLES'(1);
  localparam logic [1:0] P_NONE      = 2'b00;
  localparam logic [1:0] P_TAKEN     = 2'b01;
  localparam logic [1:0] P_NOT_TAKEN = 2'b10;

  state_t              state, state_nxt;
  logic [T_STATES-1:0] step, step_nxt;
  logic [M_CYCLES-1:0] count, count_nxt;
  logic [1:0]          p, p_nxt;
  logic                done_q, done_nxt;
  logic                fault_q, fault_nxt;
  logic                active, halted;
  logic                stall, eom;

`ifdef CYCLE_SEQ_STALL_EN
  assign stall = bus.i_Stall;
`else
  logic unused_stall;
  assign unused_stall = bus.i_Stall;
  assign stall        = 1'b0;
`endif

  // All fetch/cond/wake decisions are taken only on the unstalled last T-state.
  assign eom = step[T_STATES-1] & ~stall;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) state <= ST_RUN;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (eom && bus.i_IR_Fetch && bus.i_Halt_Req) state_nxt = ST_HALT;
      ST_HALT: if (eom && bus.i_Wake)                       state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    active = (state == ST_RUN);
    halted = (state == ST_HALT);
  end

  always_comb begin
    step_nxt  = stall ? step : {step[T_STATES-2:0], step[T_STATES-1]};
    count_nxt = count;
    p_nxt     = p;
    done_nxt  = 1'b0;
    fault_nxt = 1'b0;
    if (state == ST_HALT) begin
      count_nxt = COUNT_FIRST;
      p_nxt     = P_NONE;
    end else if (eom) begin
      if (bus.i_IR_Fetch) begin
        count_nxt = COUNT_FIRST;
        p_nxt     = P_NONE;
        done_nxt  = 1'b1;
      end else if (count[M_CYCLES-1]) begin
        // Instruction ran past the longest legal length: abandon it.
        count_nxt = COUNT_FIRST;
        p_nxt     = P_NONE;
        fault_nxt = 1'b1;
      end else begin
        count_nxt = {count[M_CYCLES-2:0], 1'b0};
        if (bus.i_Cond_Eval) p_nxt = bus.i_Cond_True ? P_TAKEN : P_NOT_TAKEN;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      step    <= STEP_FIRST;
      count   <= COUNT_FIRST;
      p       <= P_NONE;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      step    <= step_nxt;
      count   <= count_nxt;
      p       <= p_nxt;
      done_q  <= done_nxt;
      fault_q <= fault_nxt;
    end
  end

  assign bus.o_Cycle_Step  = step;
  assign bus.o_Cycle_Count = count;
  assign bus.o_P           = p;
  assign bus.o_Active      = active;
  assign bus.o_Instr_Done  = done_q;
  assign bus.o_Halted      = halted;
  assign bus.o_Fault       = fault_q;

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// tb/tb_cpu_cycle_sequencer.sv - directed table-driven bench for cpu_cycle_sequencer
module tb_cpu_cycle_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_cycle_sequencer_if #(.T_STATES(4), .M_CYCLES(8)) bus ();

  cpu_cycle_sequencer #(.T_STATES(4), .M_CYCLES(8)) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  typedef struct {
    logic       rst, fetch, ce, ct, hr, wk, st;
    int         n;
    logic [3:0] step;
    logic [7:0] count;
    logic [1:0] p;
    logic       act, done, hlt, flt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;

  task automatic add(input logic r, f, ce, ct, hr, wk, st, input int n,
                     input logic [3:0] s, input logic [7:0] c, input logic [1:0] p,
                     input logic a, d, h, fl);
    vec_t v;
    v.rst = r; v.fetch = f; v.ce = ce; v.ct = ct; v.hr = hr; v.wk = wk; v.st = st;
    v.n = n; v.step = s; v.count = c; v.p = p; v.act = a; v.done = d; v.hlt = h; v.flt = fl;
    vecs.push_back(v);
  endtask

  task automatic add_reset();
    add(1, 0, 0, 0, 0, 0, 0, 1, 4'b0001, 8'h01, 2'b00, 1, 0, 0, 0);
  endtask

  task automatic drive(input logic r, f, ce, ct, hr, wk, st);
    rst = r;
    bus.i_IR_Fetch = f; bus.i_Cond_Eval = ce; bus.i_Cond_True = ct;
    bus.i_Halt_Req = hr; bus.i_Wake = wk; bus.i_Stall = st;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [17:0] outs();
    return {bus.o_Cycle_Step, bus.o_Cycle_Count, bus.o_P, bus.o_Active,
            bus.o_Instr_Done, bus.o_Halted, bus.o_Fault};
  endfunction

  initial begin
    int faults;
    int dones;
    drive(1, 0, 0, 0, 0, 0, 0);

    // overrun with IR_Fetch held low
    add_reset();
    add(0,0,0,0,0,0,0, 4,  4'b0001, 8'h02, 2'b00, 1,0,0,0);
    add(0,0,0,0,0,0,0, 24, 4'b0001, 8'h80, 2'b00, 1,0,0,0);
    add(0,0,0,0,0,0,0, 3,  4'b1000, 8'h80, 2'b00, 1,0,0,0);
    add(0,0,0,0,0,0,0, 1,  4'b0001, 8'h01, 2'b00, 1,0,0,1);
    add(0,0,0,0,0,0,0, 1,  4'b0010, 8'h01, 2'b00, 1,0,0,0);
    // ADD SP,s8: taken at M1, fetch at M3
    add_reset();
    add(0,0,0,0,0,0,0, 4, 4'b0001, 8'h02, 2'b00, 1,0,0,0);
    add(0,0,1,1,0,0,0, 4, 4'b0001, 8'h04, 2'b01, 1,0,0,0);
    add(0,0,0,0,0,0,0, 4, 4'b0001, 8'h08, 2'b01, 1,0,0,0);
    add(0,0,0,0,0,0,0, 3, 4'b1000, 8'h08, 2'b01, 1,0,0,0);
    add(0,1,0,0,0,0,0, 1, 4'b0001, 8'h01, 2'b00, 1,1,0,0);
    add(0,0,0,0,0,0,0, 1, 4'b0010, 8'h01, 2'b00, 1,0,0,0);
    // not taken at M1, fetch at M2; then cond and fetch in the same EOM
    add_reset();
    add(0,0,0,0,0,0,0, 4, 4'b0001, 8'h02, 2'b00, 1,0,0,0);
    add(0,0,1,0,0,0,0, 4, 4'b0001, 8'h04, 2'b10, 1,0,0,0);
    add(0,0,0,0,0,0,0, 3, 4'b1000, 8'h04, 2'b10, 1,0,0,0);
    add(0,1,0,0,0,0,0, 1, 4'b0001, 8'h01, 2'b00, 1,1,0,0);
    add(0,0,1,1,0,0,0, 3, 4'b1000, 8'h01, 2'b00, 1,0,0,0);
    add(0,1,1,1,0,0,0, 1, 4'b0001, 8'h01, 2'b00, 1,1,0,0);
    // Halt_Req without fetch is ignored
    add_reset();
    add(0,0,0,0,1,0,0, 4, 4'b0001, 8'h02, 2'b00, 1,0,0,0);
    // HALT entry and wake held off to EOM
    add_reset();
    add(0,0,0,0,0,0,0, 3, 4'b1000, 8'h01, 2'b00, 1,0,0,0);
    add(0,1,0,0,1,0,0, 1, 4'b0001, 8'h01, 2'b00, 0,1,1,0);
    add(0,0,1,1,0,0,0, 1, 4'b0010, 8'h01, 2'b00, 0,0,1,0);
    add(0,0,0,0,0,1,0, 1, 4'b0100, 8'h01, 2'b00, 0,0,1,0);
    add(0,0,0,0,0,1,0, 1, 4'b1000, 8'h01, 2'b00, 0,0,1,0);
    add(0,0,0,0,0,1,0, 1, 4'b0001, 8'h01, 2'b00, 1,0,0,0);
    add(0,0,0,0,0,0,0, 4, 4'b0001, 8'h02, 2'b00, 1,0,0,0);
    // reset mid-instruction, and reset coinciding with a fetch EOM
    add_reset();
    add(0,0,1,1,0,0,0, 4, 4'b0001, 8'h02, 2'b01, 1,0,0,0);
    add(0,0,0,0,0,0,0, 4, 4'b0001, 8'h04, 2'b01, 1,0,0,0);
    add(0,0,0,0,0,0,0, 2, 4'b0100, 8'h04, 2'b01, 1,0,0,0);
    add_reset();
    add(0,0,0,0,0,0,0, 3, 4'b1000, 8'h01, 2'b00, 1,0,0,0);
    add(1,1,0,0,0,0,0, 1, 4'b0001, 8'h01, 2'b00, 1,0,0,0);
    // stall behaviour
    add_reset();
    add(0,0,0,0,0,0,0, 4, 4'b0001, 8'h02, 2'b00, 1,0,0,0);
    add(0,0,0,0,0,0,0, 2, 4'b0100, 8'h02, 2'b00, 1,0,0,0);
`ifdef CYCLE_SEQ_STALL_EN
    add(0,1,0,0,0,0,1, 5, 4'b0100, 8'h02, 2'b00, 1,0,0,0);
    add(0,0,0,0,0,0,0, 1, 4'b1000, 8'h02, 2'b00, 1,0,0,0);
    add(0,0,0,0,0,0,0, 1, 4'b0001, 8'h04, 2'b00, 1,0,0,0);
    add(0,0,0,0,0,0,0, 3, 4'b1000, 8'h04, 2'b00, 1,0,0,0);
    add(0,1,0,0,0,0,1, 2, 4'b1000, 8'h04, 2'b00, 1,0,0,0);
    add(0,0,0,0,0,0,0, 1, 4'b0001, 8'h08, 2'b00, 1,0,0,0);
`else
    add(0,0,0,0,0,0,1, 1, 4'b1000, 8'h02, 2'b00, 1,0,0,0);
    add(0,1,0,0,0,0,1, 1, 4'b0001, 8'h01, 2'b00, 1,1,0,0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].fetch, vecs[i].ce, vecs[i].ct,
            vecs[i].hr, vecs[i].wk, vecs[i].st);
      repeat (vecs[i].n) @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), 32'(outs()),
            32'({vecs[i].step, vecs[i].count, vecs[i].p, vecs[i].act,
                 vecs[i].done, vecs[i].hlt, vecs[i].flt}));
    end

    // overrun: exactly one Fault pulse (at clk 32) and no Instr_Done over 40 clocks
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    faults = 0;
    dones  = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus.o_Fault) begin
        faults++;
        check("fault_clk", 32'(c), 32'd32);
      end
      if (bus.o_Instr_Done) dones++;
    end
    check("fault_pulses", 32'(faults), 32'd1);
    check("overrun_done", 32'(dones), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
